// File: rtl/fetch_unit_pkg.sv
// Shared constants and payload types for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned PC_INC  = 2;

    // Opcode lives in the top nibble of the instruction word.
    localparam int unsigned OPC_W = 4;
    localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

    // One prefetch-queue entry: fetched word plus the PC it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory, decode and redirect signals of the fetch unit in one bundle.
interface fetch_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rdy;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] pc;
    logic              hlt;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_rdy, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_addr,
        output pc, hlt
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_rdy, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_addr,
        input  pc, hlt
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Synchronous prefetch FIFO with flush; storage is left unreset, pointers are reset.
module fetch_unit_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Qualify push/pop against full/empty and expose status.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
        count   = cnt;
        full    = (cnt == CW'(DEPTH));
        empty   = (cnt == '0);
    end

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, variable-latency memory
// requests, prefetch queue to decode, branch redirect with flush, stop at HLT.
module fetch_unit #(
    parameter int unsigned DATA_W   = fetch_unit_pkg::INSTR_W,
    parameter int unsigned ADDR_W   = fetch_unit_pkg::PC_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_INC   = fetch_unit_pkg::PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [fetch_unit_pkg::OPC_W-1:0] HLT_OPC = fetch_unit_pkg::OPC_HLT
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    import fetch_unit_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic [CW-1:0]     outstanding_q;
    logic [CW-1:0]     drop_q;
    logic              stop_q;
    logic              hlt_q;

    logic [EW-1:0]     q_head;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;

    logic [CW:0]       in_use;
    logic              issue;
    logic              accept;
    logic              rsp;
    logic              rsp_drop;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic              head_hlt;
    logic              rsp_hlt;

    // Issue gating and per-cycle handshake qualifiers.
    always_comb begin
        in_use     = (CW+1)'(q_count) + (CW+1)'(outstanding_q);
        issue      = !rst && !hlt_q && !stop_q && !bus.redirect_valid
                     && (in_use < (CW+1)'(DEPTH));
        accept     = issue && bus.imem_rdy;
        rsp        = bus.imem_rvalid;
        rsp_drop   = rsp && (drop_q != '0);
        push       = rsp && !rsp_drop && !bus.redirect_valid;
        pop        = !q_empty && bus.instr_ready;
        head_instr = q_head[EW-1 -: DATA_W];
        head_pc    = q_head[ADDR_W-1:0];
        head_hlt   = (head_instr[DATA_W-1 -: OPC_W] == HLT_OPC);
        rsp_hlt    = (bus.imem_rdata[DATA_W-1 -: OPC_W] == HLT_OPC);
    end

    // PC, response-PC, in-flight tracking, stale-drop and stop/hlt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            stop_q        <= 1'b0;
            hlt_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q + CW'(accept) - CW'(rsp);
            if (pop && head_hlt) hlt_q <= 1'b1;

            if (bus.redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc_q     <= bus.redirect_addr;
                rsp_pc_q <= bus.redirect_addr;
                drop_q   <= outstanding_q - CW'(rsp);
                stop_q   <= 1'b0;
            end else begin
                if (accept)   pc_q     <= pc_q + ADDR_W'(PC_INC);
                if (push)     rsp_pc_q <= rsp_pc_q + ADDR_W'(PC_INC);
                if (rsp_drop) drop_q   <= drop_q - CW'(1);
                if (push && rsp_hlt) stop_q <= 1'b1;
            end
        end
    end

    fetch_unit_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.imem_rdata, rsp_pc_q}),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = !q_empty;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;
    assign bus.pc          = pc_q;
    assign bus.hlt         = hlt_q;

    // Protocol and counter-range checks.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid |-> (outstanding_q != '0));
    a_push_not_full: assert property (@(posedge clk) disable iff (rst)
        push |-> !q_full);
    a_outstanding_max: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= CW'(DEPTH));
    a_drop_max: assert property (@(posedge clk) disable iff (rst)
        drop_q <= CW'(DEPTH));
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        q_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with an in-order memory model and a
// transaction-level reference model of the fetch pipeline.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst;

    fetch_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    fetch_unit #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (4),
        .PC_INC   (2),
        .RESET_PC (16'h0000),
        .HLT_OPC  (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [15:0] addr; bit stale; } mif_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Stimulus knobs.
    int          rdy_pct   = 100;
    int          ready_pct = 100;
    int          lat_lo    = 1;
    int          lat_hi    = 1;
    bit          do_rst    = 1'b1;
    bit          do_redirect = 1'b0;
    logic [15:0] redir_addr = '0;

    // Memory model and observation logs.
    mreq_t        mpend[$];
    logic [15:0]  mem_over [logic [15:0]];
    logic [15:0]  iss_log[$];
    fetch_entry_t pop_log[$];
    int           hlt_pop_cyc  = -1;
    int           hlt_rise_cyc = -1;

    // Reference model: in-flight fetches tagged stale on redirect, prefetch queue of entries.
    fetch_entry_t mq[$];
    mif_t         minf[$];
    logic [15:0]  mpc;
    bit           mstop;
    bit           mhlt;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return 16'h1000 + 16'(a >> 1);
    endfunction

    task automatic model_reset();
        mq.delete();
        minf.delete();
        mpc   = 16'h0000;
        mstop = 1'b0;
        mhlt  = 1'b0;
    endtask

    task automatic clear_logs();
        iss_log.delete();
        pop_log.delete();
        hlt_pop_cyc  = -1;
        hlt_rise_cyc = -1;
    endtask

    // One clock cycle: drive inputs after negedge, check settled outputs, advance models.
    task automatic step();
        bit           rsp;
        bit           exp_req;
        bit           acc;
        bit           pp;
        logic [15:0]  rdat;
        fetch_entry_t e;
        mif_t         f;
        @(negedge clk);
        rst                = do_rst;
        bus.imem_rdy       = ($urandom_range(99) < rdy_pct);
        bus.instr_ready    = ($urandom_range(99) < ready_pct);
        bus.redirect_valid = do_redirect;
        bus.redirect_addr  = do_redirect ? redir_addr : 16'($urandom);
        rsp  = 1'b0;
        rdat = 16'($urandom);
        if (do_rst) begin
            mpend.delete();
        end else if (mpend.size() > 0 && mpend[0].due <= cyc) begin
            rsp  = 1'b1;
            rdat = mem_word(mpend[0].addr);
            void'(mpend.pop_front());
        end
        bus.imem_rvalid = rsp;
        bus.imem_rdata  = rdat;
        #1;

        exp_req = !do_rst && !mhlt && !mstop && !do_redirect && ((mq.size() + minf.size()) < 4);
        n_tests++;
        if (bus.imem_req !== exp_req) begin
            n_fail++;
            $display("FAIL imem_req cyc=%0d got=%0b exp=%0b", cyc, bus.imem_req, exp_req);
        end
        if (!do_rst) begin
            n_tests++;
            if (bus.pc !== mpc) begin
                n_fail++;
                $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, bus.pc, mpc);
            end
            if (exp_req) begin
                n_tests++;
                if (bus.imem_addr !== mpc) begin
                    n_fail++;
                    $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, mpc);
                end
            end
            n_tests++;
            if (bus.instr_valid !== (mq.size() > 0)) begin
                n_fail++;
                $display("FAIL instr_valid cyc=%0d got=%0b exp=%0b", cyc, bus.instr_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_tests++;
                if (bus.instr !== mq[0].instr || bus.instr_pc !== mq[0].pc) begin
                    n_fail++;
                    $display("FAIL head cyc=%0d got=%h@%h exp=%h@%h", cyc, bus.instr, bus.instr_pc,
                             mq[0].instr, mq[0].pc);
                end
            end
            n_tests++;
            if (bus.hlt !== mhlt) begin
                n_fail++;
                $display("FAIL hlt cyc=%0d got=%0b exp=%0b", cyc, bus.hlt, mhlt);
            end
        end

        // Environment reacts to what the DUT actually does.
        if (!do_rst && bus.imem_req && bus.imem_rdy) begin
            mpend.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            iss_log.push_back(bus.imem_addr);
        end
        if (!do_rst && bus.instr_valid && bus.instr_ready) begin
            e.instr = bus.instr;
            e.pc    = bus.instr_pc;
            pop_log.push_back(e);
            if (bus.instr[15:12] == 4'hF && hlt_pop_cyc < 0) hlt_pop_cyc = cyc;
        end
        if (!do_rst && bus.hlt && hlt_rise_cyc < 0) hlt_rise_cyc = cyc;

        // Reference model advance.
        if (do_rst) begin
            model_reset();
        end else begin
            acc = exp_req && bus.imem_rdy;
            pp  = (mq.size() > 0) && bus.instr_ready;
            if (pp && mq[0].instr[15:12] == 4'hF) mhlt = 1'b1;
            if (do_redirect) begin
                mq.delete();
                if (rsp && minf.size() > 0) void'(minf.pop_front());
                foreach (minf[i]) minf[i].stale = 1'b1;
                mpc   = redir_addr;
                mstop = 1'b0;
            end else begin
                if (pp) void'(mq.pop_front());
                if (rsp && minf.size() > 0) begin
                    f = minf.pop_front();
                    if (!f.stale) begin
                        e.instr = rdat;
                        e.pc    = f.addr;
                        mq.push_back(e);
                        if (rdat[15:12] == 4'hF) mstop = 1'b1;
                    end
                end
                if (acc) begin
                    minf.push_back('{addr: mpc, stale: 1'b0});
                    mpc = mpc + 16'd2;
                end
            end
        end
        cyc++;
        do_redirect = 1'b0;
    endtask

    task automatic do_reset();
        do_rst = 1'b1;
        step();
        do_rst = 1'b0;
        clear_logs();
    endtask

    task automatic set_env(input int rp, input int yp, input int lo, input int hi);
        rdy_pct   = rp;
        ready_pct = yp;
        lat_lo    = lo;
        lat_hi    = hi;
    endtask

    task automatic test_reset();
        do_rst = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got req=%0b vld=%0b hlt=%0b exp 0/0/0", bus.imem_req, bus.instr_valid, bus.hlt);
        end
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_pc got pc=%h addr=%h exp 0000", bus.pc, bus.imem_addr);
        end
        do_rst = 1'b0;
        clear_logs();
        step();
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_issue got req=%0b addr=%h exp 1/0000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        int mid;
        logic [15:0] ea;
        set_env(100, 100, 1, 1);
        do_reset();
        repeat (4) step();
        mid = pop_log.size();
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            ea = 16'(2 * i);
            n_tests++;
            if (iss_log.size() <= i || iss_log[i] !== ea) begin
                n_fail++;
                $display("FAIL seq_issue[%0d] got=%h exp=%h", i, iss_log.size() > i ? iss_log[i] : 16'hxxxx, ea);
            end
        end
        n_tests++;
        if (pop_log.size() - mid != 8) begin
            n_fail++;
            $display("FAIL seq_throughput got=%0d exp=8", pop_log.size() - mid);
        end
        n_tests++;
        if (pop_log.size() == 0 || pop_log[0].instr !== 16'h1000 || pop_log[0].pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL seq_first_instr got=%0d entries exp 1000@0000", pop_log.size());
        end
    endtask

    task automatic test_backpressure();
        set_env(100, 0, 1, 1);
        do_reset();
        repeat (10) step();
        n_tests++;
        if (iss_log.size() != 4 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_limit got issued=%0d req=%0b exp 4/0", iss_log.size(), bus.imem_req);
        end
        ready_pct = 100;
        repeat (6) step();
        n_tests++;
        if (iss_log.size() < 5 || iss_log[4] !== 16'h0008) begin
            n_fail++;
            $display("FAIL bp_resume got issued=%0d exp fifth addr 0008", iss_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pop_log.size() <= i || pop_log[i].pc !== 16'(2 * i)) begin
                n_fail++;
                $display("FAIL bp_pop[%0d] got size=%0d exp pc=%h", i, pop_log.size(), 16'(2 * i));
            end
        end
    endtask

    task automatic test_redirect_drop();
        int bad;
        set_env(100, 0, 3, 3);
        do_reset();
        repeat (3) step();
        ready_pct   = 100;
        do_redirect = 1'b1;
        redir_addr  = 16'h0040;
        step();
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_no_issue got req=%0b exp 0", bus.imem_req);
        end
        repeat (12) step();
        n_tests++;
        if (pop_log.size() == 0 || pop_log[0].pc !== 16'h0040 || pop_log[0].instr !== 16'h1020) begin
            n_fail++;
            $display("FAIL rd_first got size=%0d exp 1020@0040", pop_log.size());
        end
        bad = 0;
        foreach (pop_log[i]) if (pop_log[i].pc < 16'h0040) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rd_stale got=%0d stale pops exp=0", bad);
        end
    endtask

    task automatic test_redirect_collide();
        logic [15:0] ra;
        set_env(100, 100, 1, 1);
        do_reset();
        repeat (6) step();
        ra          = 16'($urandom_range(16'h7FFE, 16'h0100)) & 16'hFFFE;
        do_redirect = 1'b1;
        redir_addr  = ra;
        step();
        n_tests++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_setup got vld=%0b req=%0b exp 1/0", bus.instr_valid, bus.imem_req);
        end
        pop_log.delete();
        step();
        n_tests++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== ra) begin
            n_fail++;
            $display("FAIL rc_after got vld=%0b req=%0b addr=%h exp 0/1/%h", bus.instr_valid, bus.imem_req,
                     bus.imem_addr, ra);
        end
        repeat (6) step();
        n_tests++;
        if (pop_log.size() == 0 || pop_log[0].pc !== ra) begin
            n_fail++;
            $display("FAIL rc_first got size=%0d exp pc=%h", pop_log.size(), ra);
        end
    endtask

    task automatic test_halt();
        set_env(100, 100, 1, 1);
        mem_over[16'h0006] = 16'hF000;
        do_reset();
        repeat (12) step();
        n_tests++;
        if (iss_log.size() != 5) begin
            n_fail++;
            $display("FAIL halt_issued got=%0d exp=5", iss_log.size());
        end
        n_tests++;
        if (hlt_pop_cyc < 0 || hlt_rise_cyc != hlt_pop_cyc + 1) begin
            n_fail++;
            $display("FAIL halt_timing got rise=%0d pop=%0d exp rise=pop+1", hlt_rise_cyc, hlt_pop_cyc);
        end
        do_redirect = 1'b1;
        redir_addr  = 16'h0020;
        step();
        step();
        n_tests++;
        if (bus.hlt !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_sticky got hlt=%0b req=%0b exp 1/0", bus.hlt, bus.imem_req);
        end
        do_rst = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset got=%0b exp=0", bus.hlt);
        end
        do_rst = 1'b0;
        clear_logs();
        mem_over.delete();
    endtask

    task automatic test_wrap_and_reset();
        set_env(100, 100, 2, 2);
        do_reset();
        do_redirect = 1'b1;
        redir_addr  = 16'hFFFC;
        step();
        iss_log.delete();
        repeat (4) step();
        n_tests++;
        if (iss_log.size() < 3 || iss_log[0] !== 16'hFFFC || iss_log[1] !== 16'hFFFE || iss_log[2] !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap got size=%0d exp FFFC,FFFE,0000", iss_log.size());
        end
        do_rst = 1'b1;
        step();
        n_tests++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req got=%0b exp=0", bus.imem_req);
        end
        step();
        n_tests++;
        if (bus.instr_valid !== 1'b0 || bus.pc !== 16'h0000 || bus.imem_addr !== 16'h0000 || bus.hlt !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got vld=%0b pc=%h addr=%h hlt=%0b exp 0/0000/0000/0",
                     bus.instr_valid, bus.pc, bus.imem_addr, bus.hlt);
        end
        do_rst = 1'b0;
        clear_logs();
        repeat (6) step();
        n_tests++;
        if (pop_log.size() == 0 || pop_log[0].pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_recover got size=%0d exp first pc 0000", pop_log.size());
        end
    endtask

    task automatic test_random();
        int total_pops;
        set_env(70, 60, 1, 4);
        do_reset();
        for (int i = 0; i < 6; i++)
            mem_over[16'($urandom_range(255)) << 1] = 16'hF000 | 16'($urandom_range(16'h0FFF));
        total_pops = 0;
        for (int i = 0; i < 2000; i++) begin
            if ((mhlt && $urandom_range(99) < 10) || $urandom_range(999) < 3) begin
                do_rst = 1'b1;
            end else if ($urandom_range(99) < 4) begin
                do_redirect = 1'b1;
                redir_addr  = 16'($urandom_range(255)) << 1;
            end
            rdy_pct   = ($urandom_range(9) == 0) ? 20 : 70;
            ready_pct = ($urandom_range(9) == 0) ? 10 : 60;
            step();
            do_rst = 1'b0;
            total_pops += pop_log.size();
            pop_log.delete();
        end
        n_tests++;
        if (total_pops < 100) begin
            n_fail++;
            $display("FAIL random_activity got=%0d pops exp>=100", total_pops);
        end
        mem_over.delete();
    endtask

    initial begin
        rst                = 1'b1;
        bus.imem_rdy       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        model_reset();

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_halt();
        test_wrap_and_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
